// File: rtl/afe_spi_capture_pkg.sv
// Shared definitions for the AFE attenuator SPI capture receiver:
// FSM encoding, bit-counter sizing and the saturating counter helper.
package afe_spi_capture_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int BITCOUNT_WIDTH = 8;
  localparam logic [BITCOUNT_WIDTH-1:0] BITCOUNT_MAX = 8'd255;
  localparam logic [BITCOUNT_WIDTH-1:0] BITCOUNT_ONE = 8'd1;

  // The frame-length counter sticks at its maximum so very long frames
  // still report as over-length instead of wrapping back to a legal size.
  function automatic logic [BITCOUNT_WIDTH-1:0] sat_inc(
    input logic [BITCOUNT_WIDTH-1:0] count
  );
    return (count == BITCOUNT_MAX) ? count : count + BITCOUNT_ONE;
  endfunction

endpackage

// File: rtl/afe_spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus a delay flop
// that turns the synchronized level into single-cycle rise/fall pulses.
module afe_spi_sync #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // All three stages share the reset value, so no edge is seen right after
  // reset unless the pin really sits at the opposite level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
      prev_q <= RESET_VALUE;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/afe_spi_capture.sv
// Listening end of the 3-wire AFE attenuator SPI link: oversamples the pins
// on sysClk, deserializes MSB-first frames and validates length at LE rise.
module afe_spi_capture
  import afe_spi_capture_pkg::*;
#(
  parameter int WORD_WIDTH        = 8,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                         sysClk,
  input  logic                         sysReset,
  input  logic                         spiClk,
  input  logic                         spiSdi,
  input  logic                         spiLe,
  input  logic                         clearErrors,
  output logic [WORD_WIDTH-1:0]        rxWord,
  output logic                         rxStrobe,
  output logic [BITCOUNT_WIDTH-1:0]    rxBitCount,
  output logic [FRAME_COUNT_WIDTH-1:0] frameCount,
  output logic                         errLength,
  output logic                         errStray,
  output state_t                       dbgState
);

  localparam logic [BITCOUNT_WIDTH-1:0]    WORD_LEN = BITCOUNT_WIDTH'(WORD_WIDTH);
  localparam logic [FRAME_COUNT_WIDTH-1:0] FRAME_ONE = FRAME_COUNT_WIDTH'(1);

  logic clk_level, clk_rise, clk_fall;
  logic sdi_level, sdi_rise, sdi_fall;
  logic le_level, le_rise, le_fall;
  logic sync_unused;

  afe_spi_sync #(.RESET_VALUE(1'b0)) u_sync_clk (
    .clk   (sysClk),
    .rst   (sysReset),
    .din   (spiClk),
    .level (clk_level),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  afe_spi_sync #(.RESET_VALUE(1'b0)) u_sync_sdi (
    .clk   (sysClk),
    .rst   (sysReset),
    .din   (spiSdi),
    .level (sdi_level),
    .rise  (sdi_rise),
    .fall  (sdi_fall)
  );

  // LE idles high, so its stages come out of reset high as well.
  afe_spi_sync #(.RESET_VALUE(1'b1)) u_sync_le (
    .clk   (sysClk),
    .rst   (sysReset),
    .din   (spiLe),
    .level (le_level),
    .rise  (le_rise),
    .fall  (le_fall)
  );

  assign sync_unused = ^{clk_level, clk_fall, sdi_rise, sdi_fall, le_level};

  state_t                      state;
  logic [WORD_WIDTH-1:0]       shift_q;
  logic [WORD_WIDTH-1:0]       shift_next;
  logic [BITCOUNT_WIDTH-1:0]   bit_cnt;

  if (WORD_WIDTH == 1) begin : g_shift_one
    assign shift_next = sdi_level;
  end else begin : g_shift_many
    assign shift_next = {shift_q[WORD_WIDTH-2:0], sdi_level};
  end

  // rxStrobe is a one-cycle pulse with no back-pressure: the word is valid in
  // the strobe cycle and stays on rxWord until the next good frame.
  // LE rise outranks a coincident spiClk rise, and a new error outranks
  // clearErrors because the set is written after the clear.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state      <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      rxWord     <= '0;
      rxStrobe   <= 1'b0;
      rxBitCount <= '0;
      frameCount <= '0;
      errLength  <= 1'b0;
      errStray   <= 1'b0;
    end else begin
      rxStrobe <= 1'b0;
      if (clearErrors) begin
        errLength <= 1'b0;
        errStray  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (clk_rise) begin
            errStray <= 1'b1;
          end
          if (le_fall) begin
            state   <= ST_SHIFT;
            shift_q <= '0;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (le_rise) begin
            state      <= ST_IDLE;
            rxBitCount <= bit_cnt;
            if (bit_cnt == WORD_LEN) begin
              rxWord     <= shift_q;
              rxStrobe   <= 1'b1;
              frameCount <= frameCount + FRAME_ONE;
            end else begin
              errLength <= 1'b1;
            end
          end else if (clk_rise) begin
            shift_q <= shift_next;
            bit_cnt <= sat_inc(bit_cnt);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbgState = state;

endmodule
